mem_port_arbiter: RTL

- Shares the single read port and single write port of the 32-bit memory model between two requesters: the instruction-fetch unit and the load/store unit.
- Provides a valid/ready request handshake and a one-cycle response pulse for each requester.
- Converts byte and halfword stores into read-modify-write sequences, because the memory only writes whole 32-bit words.
- Sits between the core's fetch/LSU front ends and the memory; the memory's own fetch port is unused in this configuration.

---
 rtl/mem_port_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch / load-store) for a single-read, single-write 32-bit memory.
// Sub-word stores become read-modify-write. Define MEM_PORT_ARB_ALIGN_CHECK_EN to fault misaligned data requests.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  fetch_req_valid,
  output logic                  fetch_req_ready,
  input  logic [ADDR_WIDTH-1:0] fetch_req_addr,
  output logic                  fetch_resp_valid,
  output logic [DATA_WIDTH-1:0] fetch_resp_data,
  input  logic                  data_req_valid,
  output logic                  data_req_ready,
  input  logic                  data_req_write,
  input  logic [1:0]            data_req_size,
  input  logic [ADDR_WIDTH-1:0] data_req_addr,
  input  logic [DATA_WIDTH-1:0] data_req_wdata,
  output logic                  data_resp_valid,
  output logic [DATA_WIDTH-1:0] data_resp_rdata,
  output logic                  data_resp_exception,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_write_data
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RMW_WR = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  logic [1:0]            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  is_data_q, is_data_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] merge_q, merge_d;
  logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;

  logic                  grant_fetch, grant_data, misaligned;
  logic [ADDR_WIDTH-1:0] data_addr_in;
  logic [DATA_WIDTH-1:0] merged;

  // Fetch wins a tie unless it was the previous winner.
  always_comb begin
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    if (state_q == IDLE && !RESET) begin
      if (fetch_req_valid && (!data_req_valid || last_grant_q == GRANT_DATA)) begin
        grant_fetch = 1'b1;
      end else if (data_req_valid) begin
        grant_data = 1'b1;
      end
    end
  end

`ifdef MEM_PORT_ARB_ALIGN_CHECK_EN
  logic exc_q, exc_d;

  always_comb begin
    misaligned = 1'b0;
    if (data_req_size == 2'd1) begin
      misaligned = data_req_addr[0];
    end else if (data_req_size[1]) begin
      misaligned = |data_req_addr[1:0];
    end
  end

  assign data_addr_in = data_req_addr;

  always_comb begin
    exc_d = exc_q;
    if (grant_data) begin
      exc_d = misaligned;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      exc_q <= 1'b0;
    end else begin
      exc_q <= exc_d;
    end
  end

  assign data_resp_exception = data_resp_valid & exc_q;
`else
  assign misaligned = 1'b0;

  // Without fault checking, low address bits are snapped to the access size.
  always_comb begin
    data_addr_in = data_req_addr;
    if (data_req_size[1]) begin
      data_addr_in[1:0] = 2'b00;
    end else if (data_req_size == 2'd1) begin
      data_addr_in[0] = 1'b0;
    end
  end

  assign data_resp_exception = 1'b0;
`endif

  // Byte lanes of the RMW merge: selected lanes take store data, the rest keep memory data.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic lane_hit;
    assign lane_hit = (size_q == 2'd0) ? (addr_q[1:0] == LANE) : (addr_q[1] == LANE[1]);
    assign merged[8*gi +: 8] = !lane_hit         ? mem_read_data[8*gi +: 8] :
                               (size_q == 2'd0)  ? wdata_q[7:0] :
                                                   wdata_q[8*(gi%2) +: 8];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    is_data_d    = is_data_q;
    write_d      = write_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    fetch_data_d = fetch_data_q;
    data_rdata_d = data_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_fetch) begin
          last_grant_d = GRANT_FETCH;
          is_data_d    = 1'b0;
          write_d      = 1'b0;
          size_d       = 2'd2;
          addr_d       = fetch_req_addr;
          state_d      = ACCESS;
        end else if (grant_data) begin
          last_grant_d = GRANT_DATA;
          is_data_d    = 1'b1;
          write_d      = data_req_write;
          size_d       = data_req_size;
          addr_d       = data_addr_in;
          wdata_d      = data_req_wdata;
          if (misaligned) begin
            data_rdata_d = '0;
            state_d      = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!is_data_q) begin
          fetch_data_d = mem_read_data;
        end else if (!write_q) begin
          data_rdata_d = mem_read_data;
        end else begin
          data_rdata_d = '0;
          if (!size_q[1]) begin
            merge_d = merged;
            state_d = RMW_WR;
          end
        end
      end
      RMW_WR:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_DATA;
      is_data_q    <= 1'b0;
      write_q      <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      merge_q      <= '0;
      fetch_data_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      is_data_q    <= is_data_d;
      write_q      <= write_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      fetch_data_q <= fetch_data_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign fetch_req_ready   = grant_fetch;
  assign data_req_ready    = grant_data;
  assign fetch_resp_valid  = !RESET && (state_q == RESP) && !is_data_q;
  assign data_resp_valid   = !RESET && (state_q == RESP) && is_data_q;
  assign fetch_resp_data   = fetch_data_q;
  assign data_resp_rdata   = data_rdata_q;
  assign mem_read_address  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_write_address = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  // Reset gates the strobe so an in-flight store can never half-complete.
  assign mem_write_enable  = !RESET && ((state_q == RMW_WR) ||
                             (state_q == ACCESS && is_data_q && write_q && size_q[1]));
  assign mem_write_data    = (state_q == RMW_WR) ? merge_q : wdata_q;
endmodule
